cell_particle_reader: RTL and testbench

CELL_PARTICLE_READER -- requirements
Module: cell_particle_reader

---
 rtl/cell_particle_reader.sv | 153 +++++++++++++++
 tb/tb_cell_particle_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_particle_reader.sv
// ============================================================================
// Module   : cell_particle_reader
// Brief    : Reads a cell's particle count from word 0, then streams words
//            1..count out through a 4-entry fall-through FIFO with handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell_particle_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] c_max_count = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNT_REQ  = 3'd1,
    S_CNT_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_FIN      = 3'd4
  } state_t;

  state_t                  r_state, w_next_state;
  logic                    r_wait_cnt;
  logic [ADDR_WIDTH-1:0]   r_count, w_count_sat;
  // One extra bit so the address counter can step past a full-range count.
  logic [ADDR_WIDTH:0]     r_next_addr;
  logic                    r_v1, r_v2;
  logic [ADDR_WIDTH-1:0]   r_id1, r_id2;
  logic [DATA_WIDTH-1:0]   r_fifo_data [4];
  logic [ADDR_WIDTH-1:0]   r_fifo_id   [4];
  logic [1:0]              r_wr_ptr, r_rd_ptr;
  logic [2:0]              r_occ;
  logic                    w_issue, w_fire, w_push, w_pop, w_fifo_empty, w_room;

  assign w_count_sat  = (mem_q[ADDR_WIDTH-1:0] > c_max_count) ? c_max_count
                                                              : mem_q[ADDR_WIDTH-1:0];
  assign w_fifo_empty = (r_occ == 3'd0);
  // Reserve a FIFO slot for every read still in the 2-cycle memory pipeline.
  assign w_room       = ((r_occ + {2'b00, r_v1} + {2'b00, r_v2}) < 3'd4);
  assign w_issue      = (r_state == S_STREAM) && (r_next_addr <= {1'b0, r_count}) && w_room;
  assign w_fire       = out_valid && out_ready;
  // Returning data bypasses the empty FIFO when it is consumed on arrival.
  assign w_push       = r_v2 && !(w_fire && w_fifo_empty);
  assign w_pop        = w_fire && !w_fifo_empty;
  assign busy         = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_rden     = 1'b0;
    mem_addr     = '0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:     if (start) w_next_state = S_CNT_REQ;
      S_CNT_REQ: begin
        mem_rden     = 1'b1;
        w_next_state = S_CNT_WAIT;
      end
      S_CNT_WAIT: if (r_wait_cnt) w_next_state = (w_count_sat == '0) ? S_FIN : S_STREAM;
      S_STREAM: begin
        if (w_issue) begin
          mem_rden = 1'b1;
          mem_addr = r_next_addr[ADDR_WIDTH-1:0];
        end
        if (w_fire && out_last) w_next_state = S_FIN;
      end
      S_FIN: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_STREAM) && (!w_fifo_empty || r_v2);
    out_data  = '0;
    out_id    = '0;
    if (!w_fifo_empty) begin
      out_data = r_fifo_data[r_rd_ptr];
      out_id   = r_fifo_id[r_rd_ptr];
    end else if (r_v2) begin
      out_data = mem_q;
      out_id   = r_id2;
    end
    out_last = out_valid && (out_id == r_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt  <= 1'b0;
      r_count     <= '0;
      r_next_addr <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_id1       <= '0;
      r_id2       <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
    end else begin
      r_wait_cnt <= (r_state == S_CNT_WAIT) ? ~r_wait_cnt : 1'b0;
      if (r_state == S_CNT_REQ) r_next_addr <= {{ADDR_WIDTH{1'b0}}, 1'b1};
      else if (w_issue)         r_next_addr <= r_next_addr + 1'b1;
      if (r_state == S_CNT_WAIT && r_wait_cnt) r_count <= w_count_sat;
      r_v1  <= w_issue;
      r_id1 <= mem_addr;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 3'd1;
        2'b01:   r_occ <= r_occ - 3'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_q;
      r_fifo_id[r_wr_ptr]   <= r_id2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cell_particle_reader.sv
// ============================================================================
// Module   : tb_cell_particle_reader
// Brief    : Scoreboard bench for cell_particle_reader with a 2-cycle memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cell_particle_reader;

  localparam int DW = 96;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, mem_rden, out_valid, out_ready, out_last;
  logic [AW-1:0] mem_addr, out_id;
  logic [DW-1:0] mem_q, out_data, r_d1;

  logic [DW-1:0] mem [256];
  int            exp_id   [$];
  logic [DW-1:0] exp_data [$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  cell_particle_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(220), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rden(mem_rden), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Memory with two-cycle read latency; garbage when not enabled.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    r_d1  <= mem_rden ? mem[mem_addr] : {3{32'hdeadbeef}};
    mem_q <= r_d1;
  end

  task automatic load_cell(input int cnt_field, output int eff);
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[0][7:0] = cnt_field[7:0];
    eff = (cnt_field > 219) ? 219 : cnt_field;
    exp_id.delete();
    exp_data.delete();
    for (int i = 1; i <= eff; i++) begin
      exp_id.push_back(i);
      exp_data.push_back(mem[i]);
    end
  endtask

  // mode 0: ready always 1; 1: ready 0 for stall_n cycles; 2: random ready
  task automatic run_cell(input int eff, input int mode, input int stall_n,
                          output int first_valid, output int last_hs, output int done_cyc,
                          output int stalled_reads, output int n_hs);
    int s, id_e;
    logic [DW-1:0] d_e, p_data;
    logic [AW-1:0] p_id;
    logic p_valid, p_ready, p_last, seen_done;
    first_valid = -1; last_hs = -1; done_cyc = -1; stalled_reads = 0; n_hs = 0;
    p_valid = 0; p_ready = 0; p_last = 0; p_data = '0; p_id = '0; seen_done = 0;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) begin
        @(negedge clk);
        start = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k >= stall_n);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 1 && k < stall_n && mem_rden && mem_addr != '0) stalled_reads++;
      if (p_valid && !p_ready) begin
        total++;
        if (!out_valid || out_data !== p_data || out_id !== p_id || out_last !== p_last) begin
          bad++;
          $display("FAIL hold_stable cyc=%0d got v=%b id=%0d last=%b, need v=1 id=%0d last=%b data unchanged",
                   k, out_valid, out_id, out_last, p_id, p_last);
        end
      end
      if (out_valid && first_valid < 0) first_valid = cyc - s;
      if (out_valid && out_ready) begin
        total++;
        if (exp_id.size() == 0) begin
          bad++;
          $display("FAIL extra_particle got id=%0d, need no output", out_id);
        end else begin
          id_e = exp_id.pop_front();
          d_e  = exp_data.pop_front();
          if (int'(out_id) !== id_e || out_data !== d_e || out_last !== (id_e == eff)) begin
            bad++;
            $display("FAIL particle got id=%0d last=%b data=%h, need id=%0d last=%b data=%h",
                     out_id, out_last, out_data, id_e, (id_e == eff), d_e);
          end
        end
        n_hs++;
        last_hs = cyc - s;
      end
      if (done) begin
        done_cyc  = cyc - s;
        seen_done = 1;
        break;
      end
      p_valid = out_valid; p_ready = out_ready; p_data = out_data; p_id = out_id; p_last = out_last;
    end
    start = 1'b0;
    total++;
    if (!seen_done || exp_id.size() != 0) begin
      bad++;
      $display("FAIL completion got done=%b left=%0d, need done=1 left=0", seen_done, exp_id.size());
    end
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({busy, done, mem_rden, out_valid, out_last, mem_addr, out_id, out_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b rden=%b valid=%b addr=%0d id=%0d, need all 0",
               busy, done, mem_rden, out_valid, mem_addr, out_id);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count5();
    int eff, fv, lh, dc, sr, nh;
    load_cell(5, eff);
    run_cell(eff, 0, 0, fv, lh, dc, sr, nh);
    total++;
    if (fv !== 6 || lh !== 10 || dc !== 11 || nh !== 5) begin
      bad++;
      $display("FAIL count5_timing got first=%0d last=%0d done=%0d n=%0d, need 6 10 11 5", fv, lh, dc, nh);
    end
  endtask

  task automatic test_count0();
    int eff, fv, lh, dc, sr, nh;
    load_cell(0, eff);
    run_cell(eff, 0, 0, fv, lh, dc, sr, nh);
    total++;
    if (fv !== -1 || dc !== 4) begin
      bad++;
      $display("FAIL count0 got first_valid=%0d done=%0d, need -1 4", fv, dc);
    end
  endtask

  task automatic test_stall();
    int eff, fv, lh, dc, sr, nh;
    load_cell(10, eff);
    run_cell(eff, 1, 20, fv, lh, dc, sr, nh);
    total++;
    if (sr > 4 || sr < 1 || nh !== 10) begin
      bad++;
      $display("FAIL stall got reads_while_stalled=%0d n=%0d, need 1..4 and 10", sr, nh);
    end
  endtask

  task automatic test_saturate();
    int eff, fv, lh, dc, sr, nh;
    load_cell(250, eff);
    run_cell(eff, 0, 0, fv, lh, dc, sr, nh);
    total++;
    if (nh !== 219) begin
      bad++;
      $display("FAIL saturate got n=%0d, need 219", nh);
    end
  endtask

  task automatic test_random_ready();
    int eff, fv, lh, dc, sr, nh;
    load_cell(50, eff);
    run_cell(eff, 2, 0, fv, lh, dc, sr, nh);
    total++;
    if (nh !== 50) begin
      bad++;
      $display("FAIL random_ready got n=%0d, need 50", nh);
    end
  endtask

  task automatic test_reset_mid();
    int eff, fv, lh, dc, sr, nh, got3, stray;
    logic [DW-1:0] d_e;
    int id_e;
    load_cell(8, eff);
    out_ready = 1'b1;
    got3 = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 100 && got3 == 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        total++;
        id_e = exp_id.pop_front();
        d_e  = exp_data.pop_front();
        if (int'(out_id) !== id_e || out_data !== d_e) begin
          bad++;
          $display("FAIL pre_reset got id=%0d, need id=%0d", out_id, id_e);
        end
        if (id_e == 3) got3 = 1;
      end
    end
    rst = 1'b1;
    #1;
    total++;
    if (got3 == 0 || {busy, done, mem_rden, out_valid, out_last, mem_addr, out_id, out_data} !== '0) begin
      bad++;
      $display("FAIL mid_reset got reached3=%0d busy=%b valid=%b id=%0d addr=%0d, need 1 and all 0",
               got3, busy, out_valid, out_id, mem_addr);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || out_valid || busy) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL post_reset_quiet got %0d active cycles, need 0", stray);
    end
    load_cell(7, eff);
    run_cell(eff, 0, 0, fv, lh, dc, sr, nh);
    total++;
    if (fv !== 6 || nh !== 7) begin
      bad++;
      $display("FAIL rerun got first=%0d n=%0d, need 6 7", fv, nh);
    end
  endtask

  initial begin
    test_reset();
    test_count5();
    test_count0();
    test_stall();
    test_saturate();
    test_random_ready();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
